// File: rtl/uart_tx_buffered_if.sv
// Byte handshake between an on-chip producer and the buffered UART transmitter.
//   in_data  : byte offered by the producer
//   in_valid : producer has a byte on in_data this cycle
//   in_ready : transmitter accepts the byte on this cycle's rising edge
// master = producer side, slave = transmitter side.
interface uart_tx_buffered_if;
    logic [7:0] in_data;
    logic       in_valid;
    logic       in_ready;

    modport master (output in_data, output in_valid, input in_ready);
    modport slave  (input in_data, input in_valid, output in_ready);
endinterface

// File: rtl/uart_tx_buffered.sv
// Buffered UART transmitter: bytes pushed over a valid/ready handshake are held
// in a circular FIFO and sent on tx as 8N1 frames (start, 8 data LSB first, stop).
// Ports:
//   clk     : system clock, rising edge
//   rst_n   : synchronous active-low reset
//   in_if   : producer handshake (in_data / in_valid / in_ready)
//   tx      : registered serial line, idles high
//   busy    : serializer is not in IDLE
//   count   : bytes waiting in the FIFO (not counting the one being shifted)
//
// state | meaning
// IDLE  | line high, waiting for a byte in the FIFO
// START | start bit (low) for CLKS_PER_BIT cycles
// DATA  | eight data bits, LSB first, CLKS_PER_BIT cycles each
// STOP  | stop bit (high); chains straight into START if more bytes wait
module uart_tx_buffered #(
    parameter int CLKS_PER_BIT = 234,
    parameter int DEPTH        = 16
) (
    input  logic                   clk,
    input  logic                   rst_n,
    uart_tx_buffered_if.slave      in_if,
    output logic                   tx,
    output logic                   busy,
    output logic [$clog2(DEPTH):0] count
);
    localparam int AW = $clog2(DEPTH);
    localparam int BW = $clog2(CLKS_PER_BIT);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t         state, state_next;
    logic [7:0]     mem [DEPTH];
    logic [AW-1:0]  wr_ptr, rd_ptr;
    logic [7:0]     shift, shift_next;
    logic [2:0]     bit_cnt, bit_next;
    logic [BW-1:0]  baud_cnt, baud_next;
    logic           tx_next;
    logic           push, pop, baud_end;

    // Ready comes only from the registered count, so a pop on the same edge
    // never lets a push into a full FIFO.
    assign in_if.in_ready = rst_n && (count != (AW+1)'(DEPTH));
    assign push           = in_if.in_valid && in_if.in_ready;
    assign baud_end       = (baud_cnt == BW'(CLKS_PER_BIT - 1));
    assign busy           = (state != IDLE);

    always_comb begin
        state_next = state;
        shift_next = shift;
        bit_next   = bit_cnt;
        baud_next  = baud_cnt + BW'(1);
        pop        = 1'b0;
        case (state)
            IDLE: begin
                baud_next = '0;
                if (count != '0) begin
                    pop        = 1'b1;
                    shift_next = mem[rd_ptr];
                    bit_next   = '0;
                    state_next = START;
                end
            end
            START: begin
                if (baud_end) begin
                    baud_next  = '0;
                    state_next = DATA;
                end
            end
            DATA: begin
                if (baud_end) begin
                    baud_next  = '0;
                    shift_next = {1'b0, shift[7:1]};
                    bit_next   = bit_cnt + 3'd1;
                    if (bit_cnt == 3'd7) begin
                        state_next = STOP;
                    end
                end
            end
            STOP: begin
                if (baud_end) begin
                    baud_next = '0;
                    // Chain the next frame without an idle cycle.
                    if (count != '0) begin
                        pop        = 1'b1;
                        shift_next = mem[rd_ptr];
                        bit_next   = '0;
                        state_next = START;
                    end else begin
                        state_next = IDLE;
                    end
                end
            end
            default: state_next = IDLE;
        endcase

        // tx is registered from the next-state view so the line level lines up
        // exactly with the state it belongs to.
        case (state_next)
            START:   tx_next = 1'b0;
            DATA:    tx_next = shift_next[0];
            default: tx_next = 1'b1;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= IDLE;
            shift    <= '0;
            bit_cnt  <= '0;
            baud_cnt <= '0;
            tx       <= 1'b1;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
        end else begin
            state    <= state_next;
            shift    <= shift_next;
            bit_cnt  <= bit_next;
            baud_cnt <= baud_next;
            tx       <= tx_next;
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({push, pop})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: count <= count;
            endcase
        end
    end

    // Storage needs no reset: the pointers and count define what is valid.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= in_if.in_data;
    end
endmodule

// File: tb/tb_uart_tx_buffered.sv
module tb_uart_tx_buffered;
    localparam int CPB   = 4;
    localparam int DEPTH = 16;
    localparam int FRAME = 10 * CPB;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       tx, busy;
    logic [4:0] count;

    uart_tx_buffered_if bus ();

    uart_tx_buffered #(.CLKS_PER_BIT(CPB), .DEPTH(DEPTH)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .in_if (bus),
        .tx    (tx),
        .busy  (busy),
        .count (count)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;
    int cyc = 0;
    int frames_done = 0;
    logic [7:0] exp_q[$];
    int start_q[$];

    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    // Frame monitor: sees a start bit, pops the scoreboard, and compares every
    // cycle of the 40-cycle frame against the ideal waveform.
    initial begin
        forever begin
            @(negedge clk);
            if (rst_n === 1'b1 && tx === 1'b0) begin
                logic [7:0] e;
                logic [7:0] obs;
                logic [9:0] wave;
                bit ok, aborted, have;
                int bi;
                start_q.push_back(cyc);
                have = (exp_q.size() != 0);
                e = 8'h00;
                if (have) e = exp_q.pop_front();
                wave = {1'b1, e, 1'b0};
                obs = 8'h00;
                ok = 1'b1;
                aborted = 1'b0;
                for (int k = 0; k < FRAME; k++) begin
                    if (k != 0) @(negedge clk);
                    if (rst_n !== 1'b1) begin
                        aborted = 1'b1;
                        break;
                    end
                    bi = k / CPB;
                    if (tx !== wave[bi]) ok = 1'b0;
                    if ((k % CPB) == CPB / 2 && bi >= 1 && bi <= 8) obs[bi-1] = tx;
                end
                if (!aborted) begin
                    total++;
                    assert (have && ok) else begin
                        bad++;
                        $error("FAIL frame: observed byte=%h shape_ok=%0d queued=%0d expected byte=%h",
                               obs, ok, have, e);
                    end
                    frames_done++;
                end
            end
        end
    end

    task automatic push_byte(input logic [7:0] b, output int edge_cyc);
        int n;
        n = 0;
        @(negedge clk);
        bus.in_data  = b;
        bus.in_valid = 1'b1;
        while (bus.in_ready !== 1'b1 && n < 2000) begin
            @(negedge clk);
            n++;
        end
        check("push_wait", (n < 2000), 1);
        if (bus.in_ready === 1'b1) exp_q.push_back(b);
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        edge_cyc = cyc;
    endtask

    task automatic drain(input string tag, input int limit);
        int n;
        n = 0;
        @(negedge clk);
        while ((busy !== 1'b0 || count !== 5'd0 || exp_q.size() != 0) && n < limit) begin
            @(negedge clk);
            n++;
        end
        check(tag, (n < limit), 1);
    endtask

    task automatic busy_len(output int n);
        int k;
        k = 0;
        n = 0;
        @(negedge clk);
        while (busy !== 1'b1 && k < 100) begin
            @(negedge clk);
            k++;
        end
        while (busy === 1'b1 && n < 5000) begin
            n++;
            @(negedge clk);
        end
    endtask

    initial begin
        int e0, e1, f0, s0, n, acc, target, pop_edge;
        logic [7:0] d;

        bus.in_data  = 8'h00;
        bus.in_valid = 1'b0;
        rst_n        = 1'b0;

        // Reset values
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_tx", tx, 1);
        check("rst_busy", busy, 0);
        check("rst_count", count, 0);
        check("rst_in_ready", bus.in_ready, 0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        check("rel_in_ready", bus.in_ready, 1);
        check("rel_tx", tx, 1);

        // Single byte 0xA5
        f0 = frames_done;
        push_byte(8'hA5, e0);
        @(negedge clk);
        check("single_count_after_push", count, 1);
        check("single_tx_before_pop", tx, 1);
        @(negedge clk);
        check("single_tx_fall", tx, 0);
        check("single_busy_rise", busy, 1);
        check("single_count_after_pop", count, 0);
        n = 1;
        @(negedge clk);
        while (busy === 1'b1 && n < 500) begin
            n++;
            @(negedge clk);
        end
        check("single_busy_len", n, FRAME);
        check("single_tx_idle", tx, 1);
        check("single_busy_end", busy, 0);
        check("single_frames", frames_done - f0, 1);

        // Back-to-back 0x00, 0xFF
        f0 = frames_done;
        s0 = start_q.size();
        push_byte(8'h00, e0);
        push_byte(8'hFF, e1);
        check("b2b_push_gap", e1 - e0, 1);
        busy_len(n);
        check("b2b_busy_len", n, 2 * FRAME);
        check("b2b_frames", frames_done - f0, 2);
        if (start_q.size() >= s0 + 2)
            check("b2b_contiguous", start_q[s0+1] - start_q[s0], FRAME);
        else
            check("b2b_start_count", start_q.size() - s0, 2);

        // Full boundary: valid held for 20 cycles with incrementing data
        f0  = frames_done;
        acc = 0;
        d   = 8'h01;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            bus.in_valid = 1'b1;
            bus.in_data  = d;
            if (bus.in_ready === 1'b1) begin
                exp_q.push_back(d);
                acc++;
                d++;
            end
        end
        @(posedge clk);
        #1 bus.in_valid = 1'b0;
        @(negedge clk);
        check("full_accepted", acc, 17);
        check("full_count", count, 16);
        check("full_in_ready", bus.in_ready, 0);
        drain("full_drain", 17 * FRAME + 200);
        check("full_frames", frames_done - f0, 17);

        // Simultaneous push and pop with count=3
        f0 = frames_done;
        push_byte(8'h11, e0);
        push_byte(8'h22, e1);
        push_byte(8'h33, e1);
        push_byte(8'h44, e1);
        @(negedge clk);
        check("sim_count_before", count, 3);
        pop_edge = e0 + 1;
        target   = pop_edge + FRAME;
        n = 0;
        while (cyc < target - 1 && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("sim_reach_target", cyc, target - 1);
        check("sim_ready", bus.in_ready, 1);
        bus.in_data  = 8'h55;
        bus.in_valid = 1'b1;
        exp_q.push_back(8'h55);
        @(posedge clk);
        #1 bus.in_valid = 1'b0;
        @(negedge clk);
        check("sim_count_after", count, 3);
        check("sim_next_start", tx, 0);
        check("sim_busy", busy, 1);
        drain("sim_drain", 6 * FRAME + 200);
        check("sim_frames", frames_done - f0, 5);

        // Reset during data bit 4 with 5 bytes queued
        push_byte(8'h61, e0);
        push_byte(8'h62, e1);
        push_byte(8'h63, e1);
        push_byte(8'h64, e1);
        push_byte(8'h65, e1);
        push_byte(8'h66, e1);
        pop_edge = e0 + 1;
        n = 0;
        while (cyc < pop_edge + 21 && n < 200) begin
            @(negedge clk);
            n++;
        end
        @(posedge clk);
        #1 rst_n = 1'b0;
        f0 = frames_done;
        @(negedge clk);
        check("mid_rst_count_before", count, 5);
        @(negedge clk);
        check("mid_rst_tx", tx, 1);
        check("mid_rst_count", count, 0);
        check("mid_rst_busy", busy, 0);
        check("mid_rst_in_ready", bus.in_ready, 0);
        exp_q.delete();
        @(posedge clk);
        #1 rst_n = 1'b1;
        push_byte(8'h3C, e0);
        drain("post_rst_drain", 2 * FRAME + 100);
        check("post_rst_frames", frames_done - f0, 1);
        repeat (60) @(negedge clk);
        check("post_rst_no_stale", frames_done - f0, 1);
        check("post_rst_tx_idle", tx, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/uart_tx_buffered.md
# uart_tx_buffered

Buffered UART transmit path: accepts bytes from an on-chip producer over a valid/ready handshake, queues them in an internal FIFO, and serializes them onto the `tx` line as 8N1 frames. It is the counterpart of the receive-into-FIFO path. Any logic that must stream bytes to a host, such as status reports or command responses, pushes into this block without tracking line timing.

## Interface
- `CLKS_PER_BIT`, 234: clock cycles per UART bit; must be ≥ 2.
- `DEPTH`, 16: FIFO depth in bytes; must be a power of 2 and ≥ 2.
- `clk`  in  1  system clock; all logic on the rising edge.
- `rst_n`  in  1  reset; synchronous, active-low.
- `in_data`  in  8  byte to queue.
- `in_valid`  in  1  producer offers `in_data` this cycle.
- `in_ready`  out  1  block accepts a byte this cycle.
- `tx`  out  1  serial line, registered output, idles high.
- `busy`  out  1  high whenever the serializer is not in IDLE.
- `count`  out  $clog2(DEPTH)+1  number of bytes stored in the FIFO, excluding the byte currently being shifted.

## Operation
- **Push.** A push occurs on an edge where `in_valid && in_ready`.
  - `in_ready = rst_n && (count != DEPTH)`. It is combinational from the registered `count` and is never raised by a same-cycle pop.
  - `in_data` is ignored whenever `in_ready` is low.
- **FIFO.** Circular buffer with write and read pointers of $clog2(DEPTH) bits.
  - Both pointers wrap modulo DEPTH.
  - `count` increments on a push, decrements on a pop, and holds when both or neither occur.
- **Serializer states:** IDLE, START, DATA, STOP.
  - **IDLE:** `tx`=1. If `count>0`, pop the head into the shift register, clear the bit counter and the baud counter, and go to START.
  - **START:** `tx`=0 for CLKS_PER_BIT cycles, then go to DATA.
  - **DATA:** drive `tx`=shift[0] for CLKS_PER_BIT cycles, then shift right. After 8 bits (bit index 7 complete) go to STOP. Bits go out LSB first.
  - **STOP:** `tx`=1 for CLKS_PER_BIT cycles. At the end, if `count>0`, pop and go directly to START with no idle gap. Otherwise go to IDLE.
- **Baud counter.** Width $clog2(CLKS_PER_BIT). Counts 0..CLKS_PER_BIT-1 and resets on every state or bit change.
- **Reset.** While `rst_n` is low at an edge:
  - `tx`=1, `busy`=0, `count`=0, both pointers=0, state=IDLE, and both counters=0.
  - FIFO contents are discarded.
  - `in_ready`=0 while `rst_n` is low.
  - A reset mid-frame aborts the frame, and `tx` is high from the next edge.

## Timing
- **Frame length.** Exactly 10×CLKS_PER_BIT cycles: start, 8 data, stop.
- **Back-to-back frames.** With a non-empty FIFO, the next start bit begins on the cycle immediately after the last stop-bit cycle, so frames are contiguous.
- **First-byte latency.** Push at edge E into an empty FIFO while IDLE:
  - `count`=1 after E.
  - The pop happens at E+1, when `tx` falls, `busy` rises and `count` returns to 0.
- **Same-cycle push and pop.** Both take effect and `count` is unchanged.
- **Push into a full FIFO.** Refused, even if a pop occurs on the same edge.
- **Line integrity.** `tx` changes only at bit boundaries and never glitches, since it is driven from a register.
- **End of activity.** `busy` falls on the edge leaving STOP to IDLE.

## Test plan
- **Reset values.** Hold `rst_n`=0 for 3 cycles. Required: `tx`=1, `busy`=0, `count`=0, `in_ready`=0. After release, `in_ready`=1.
- **Single byte.** CLKS_PER_BIT=4; push 0xA5 once. Required:
  - `tx` falls 1 cycle after the accepting edge.
  - Each bit lasts 4 cycles, in the sequence 0,1,0,1,0,0,1,0,1,1.
  - `busy` is high for exactly 40 cycles, then `tx`=1 and `busy`=0.
- **Back-to-back bytes.** Push 0x00, then 0xFF on the next cycle. Required:
  - Two contiguous frames totalling 80 cycles.
  - The stop bit of frame 1 is followed immediately by the start bit of frame 2.
  - `busy` never drops between the frames.
- **Full boundary.** CLKS_PER_BIT=4, `in_valid` held high for 20 cycles with incrementing data 0x01…. Required:
  - Exactly 17 bytes are accepted (1 shifting plus 16 stored).
  - `count`=16 and `in_ready` low until the first frame ends.
  - Bytes 0x01–0x11 emerge in order, and pointer wrap-around is exercised.
- **Simultaneous push/pop.** With `count`=3, push on the edge that ends a stop bit. Required: `count` remains 3 and the next frame starts immediately.
- **Reset mid-frame.** Assert `rst_n`=0 during data bit 4 with 5 bytes queued. Required:
  - `tx`=1 at the next edge, with `count`=0 and `busy`=0.
  - After release, a new push of 0x3C transmits correctly and no stale bytes appear.
